cmn_rst_ctrl: RTL and testbench

// - Reset sequencer driving NUM_DOM downstream active-low domain resets (feeds rst_n of cmn_rst_intf instances).
// - Holds all domains in reset for HOLD_CYC cycles, then releases them one by one, STAGGER_CYC apart, index 0 first.
// - Accepts software reset requests on a 4-phase req/ack handshake and replays the full sequence.
// - Sits in the common vkit as the single source of ordered reset for multi-domain benches.
//

---
 rtl/cmn_rst_ctrl.sv | 171 +++++++++++++++++
 tb/tb_cmn_rst_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmn_rst_ctrl.sv
// -----------------------------------------------------------------------------
// cmn_rst_ctrl -- ordered reset sequencer for multi-domain benches.
//
// Holds every downstream domain in reset for HOLD_CYC cycles, then releases
// the domains one at a time, STAGGER_CYC cycles apart, index 0 first. A
// software reset request on a 4-phase req/ack handshake replays the whole
// sequence. The power-on sequence never raises the acknowledge.
//
// Optional feature macro: CMN_RST_CTRL_CNT_EN
//   defined     -> rst_cnt port present, counts accepted software resets
//                  (saturating at 16'hFFFF, cleared only by rst)
//   not defined -> rst_cnt port and counter absent
//
// Ports
//   clk         in   1        single clock, all logic on posedge
//   rst         in   1        synchronous active-high master reset
//   sw_rst_req  in   1        software reset request (level, 4-phase)
//   sw_rst_ack  out  1        request acknowledge
//   dom_rst_n   out  NUM_DOM  per-domain active-low reset, registered
//   all_up      out  1        every domain released
//   busy        out  1        sequence in progress (not RUN)
//   rst_cnt     out  16       software reset count (CMN_RST_CTRL_CNT_EN only)
// -----------------------------------------------------------------------------
module cmn_rst_ctrl #(
  parameter int NUM_DOM     = 4,
  parameter int HOLD_CYC    = 16,
  parameter int STAGGER_CYC = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sw_rst_req,
  output logic               sw_rst_ack,
  output logic [NUM_DOM-1:0] dom_rst_n,
  output logic               all_up,
  output logic               busy
`ifdef CMN_RST_CTRL_CNT_EN
  ,
  output logic [15:0]        rst_cnt
`endif
);

  localparam int MAX_CYC = (HOLD_CYC > STAGGER_CYC) ? HOLD_CYC : STAGGER_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam int IW      = $clog2(NUM_DOM + 1);

  localparam logic [CW-1:0]      HOLD_LAST = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0]      STAG_LAST = CW'(STAGGER_CYC - 1);
  localparam logic [IW-1:0]      IDX_LAST  = IW'(NUM_DOM - 1);
  localparam logic [NUM_DOM-1:0] DOM_ONE   = NUM_DOM'(1);

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2,
    ASSERT  = 2'd3
  } state_t;

  state_t        state_r;
  logic [CW-1:0] hold_cnt_r;
  logic [CW-1:0] stag_cnt_r;
  logic [IW-1:0] idx_r;
  // Set while the running sequence was started by a requester that still
  // holds its request; decides whether completion raises the acknowledge.
  logic          sw_seq_r;

  // Sequencer FSM: counters, domain releases and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= HOLD;
      hold_cnt_r <= '0;
      stag_cnt_r <= '0;
      idx_r      <= '0;
      sw_seq_r   <= 1'b0;
      dom_rst_n  <= '0;
      all_up     <= 1'b0;
      busy       <= 1'b1;
      sw_rst_ack <= 1'b0;
`ifdef CMN_RST_CTRL_CNT_EN
      rst_cnt    <= 16'h0000;
`endif
    end else begin
      case (state_r)
        // ASSERT is the one-cycle entry of a software sequence; it counts the
        // hold phase exactly like HOLD so its entry edge acts as edge E.
        HOLD, ASSERT: begin
          if (!sw_rst_req) begin
            sw_seq_r <= 1'b0;
          end
          if (hold_cnt_r == HOLD_LAST) begin
            hold_cnt_r <= '0;
            stag_cnt_r <= '0;
            dom_rst_n  <= dom_rst_n | DOM_ONE;
            if (NUM_DOM == 1) begin
              state_r    <= RUN;
              idx_r      <= '0;
              all_up     <= 1'b1;
              busy       <= 1'b0;
              sw_rst_ack <= sw_seq_r & sw_rst_req;
            end else begin
              state_r <= RELEASE;
              idx_r   <= IW'(1);
            end
          end else begin
            hold_cnt_r <= hold_cnt_r + CW'(1);
            state_r    <= HOLD;
          end
        end
        RELEASE: begin
          if (!sw_rst_req) begin
            sw_seq_r <= 1'b0;
          end
          if (stag_cnt_r == STAG_LAST) begin
            stag_cnt_r <= '0;
            dom_rst_n  <= dom_rst_n | (DOM_ONE << idx_r);
            if (idx_r == IDX_LAST) begin
              state_r    <= RUN;
              idx_r      <= '0;
              all_up     <= 1'b1;
              busy       <= 1'b0;
              sw_rst_ack <= sw_seq_r & sw_rst_req;
            end else begin
              idx_r <= idx_r + IW'(1);
            end
          end else begin
            stag_cnt_r <= stag_cnt_r + CW'(1);
          end
        end
        RUN: begin
          if (sw_rst_ack) begin
            // Handshake completion: drop ack once the requester lets go.
            if (!sw_rst_req) begin
              sw_rst_ack <= 1'b0;
            end else begin
              sw_rst_ack <= 1'b1;
            end
          end else if (sw_rst_req) begin
            state_r    <= ASSERT;
            hold_cnt_r <= '0;
            stag_cnt_r <= '0;
            idx_r      <= '0;
            sw_seq_r   <= 1'b1;
            dom_rst_n  <= '0;
            all_up     <= 1'b0;
            busy       <= 1'b1;
`ifdef CMN_RST_CTRL_CNT_EN
            if (rst_cnt != 16'hFFFF) begin
              rst_cnt <= rst_cnt + 16'h0001;
            end else begin
              rst_cnt <= rst_cnt;
            end
`endif
          end else begin
            state_r <= RUN;
          end
        end
        default: begin
          state_r    <= HOLD;
          hold_cnt_r <= '0;
          stag_cnt_r <= '0;
          idx_r      <= '0;
          sw_seq_r   <= 1'b0;
          dom_rst_n  <= '0;
          all_up     <= 1'b0;
          busy       <= 1'b1;
          sw_rst_ack <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmn_rst_ctrl.sv
// Scoreboard bench for cmn_rst_ctrl. Stimulus pushes the hand-computed output
// changes (edge number + value) into a queue per DUT; a negedge monitor pops
// and compares whenever a DUT output tuple changes.
module tb_cmn_rst_ctrl;

`ifdef CMN_RST_CTRL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct {
    int          cyc;
    logic [22:0] val;
  } exp_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  exp_t q0[$];
  exp_t q1[$];

  // DUT0: default parameters
  logic        rst0 = 1'b1;
  logic        req0 = 1'b0;
  logic        ack0, up0, busy0;
  logic [3:0]  dom0;
  logic [15:0] cnt0;

  // DUT1: single domain, one-cycle hold
  logic        rst1 = 1'b1;
  logic        req1 = 1'b0;
  logic        ack1, up1, busy1;
  logic [0:0]  dom1;
  logic [15:0] cnt1;

`ifndef CMN_RST_CTRL_CNT_EN
  assign cnt0 = 16'h0000;
  assign cnt1 = 16'h0000;
`endif

  cmn_rst_ctrl #(.NUM_DOM(4), .HOLD_CYC(16), .STAGGER_CYC(4)) dut0 (
    .clk(clk), .rst(rst0), .sw_rst_req(req0), .sw_rst_ack(ack0),
    .dom_rst_n(dom0), .all_up(up0), .busy(busy0)
`ifdef CMN_RST_CTRL_CNT_EN
    , .rst_cnt(cnt0)
`endif
  );

  cmn_rst_ctrl #(.NUM_DOM(1), .HOLD_CYC(1), .STAGGER_CYC(1)) dut1 (
    .clk(clk), .rst(rst1), .sw_rst_req(req1), .sw_rst_ack(ack1),
    .dom_rst_n(dom1), .all_up(up1), .busy(busy1)
`ifdef CMN_RST_CTRL_CNT_EN
    , .rst_cnt(cnt1)
`endif
  );

  always #5 clk = ~clk;

  // Edge counter: after posedge n, cyc == n.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [15:0] kc(input logic [15:0] k);
    return CNT_EN ? k : 16'h0000;
  endfunction

  function automatic void push0(input int c, input logic [3:0] d, input logic u,
                                input logic b, input logic a, input logic [15:0] k);
    exp_t e;
    e.cyc = c;
    e.val = {d, u, b, a, kc(k)};
    q0.push_back(e);
  endfunction

  function automatic void push1(input int c, input logic d, input logic u,
                                input logic b, input logic a, input logic [15:0] k);
    exp_t e;
    e.cyc = c;
    e.val = {3'b000, d, u, b, a, kc(k)};
    q1.push_back(e);
  endfunction

  // Releases of a 4-domain sequence whose start edge is e.
  function automatic void push_rel0(input int e, input logic a, input logic [15:0] k);
    push0(e + 16, 4'b0001, 1'b0, 1'b1, 1'b0, k);
    push0(e + 20, 4'b0011, 1'b0, 1'b1, 1'b0, k);
    push0(e + 24, 4'b0111, 1'b0, 1'b1, 1'b0, k);
    push0(e + 28, 4'b1111, 1'b1, 1'b0, a, k);
  endfunction

  // Monitor: compare every output change against the head of the queue.
  logic [22:0] prev0 = 'x;
  logic [22:0] prev1 = 'x;
  always @(negedge clk) begin
    logic [22:0] act0;
    logic [22:0] act1;
    exp_t        e;
    act0 = {dom0, up0, busy0, ack0, cnt0};
    act1 = {3'b000, dom1, up1, busy1, ack1, cnt1};
    if (act0 !== prev0) begin
      n_chk++;
      if (q0.size() == 0) begin
        n_fail++;
        $display("FAIL dut0_unexpected cyc=%0d actual=%h required=no change", cyc, act0);
      end else begin
        e = q0.pop_front();
        if (e.cyc != cyc || e.val !== act0) begin
          n_fail++;
          $display("FAIL dut0_event actual cyc=%0d val=%h required cyc=%0d val=%h",
                   cyc, act0, e.cyc, e.val);
        end
      end
      prev0 = act0;
    end
    if (act1 !== prev1) begin
      n_chk++;
      if (q1.size() == 0) begin
        n_fail++;
        $display("FAIL dut1_unexpected cyc=%0d actual=%h required=no change", cyc, act1);
      end else begin
        e = q1.pop_front();
        if (e.cyc != cyc || e.val !== act1) begin
          n_fail++;
          $display("FAIL dut1_event actual cyc=%0d val=%h required cyc=%0d val=%h",
                   cyc, act1, e.cyc, e.val);
        end
      end
      prev1 = act1;
    end
  end

  // DUT1 stimulus: one-domain sequence and request deferred out of HOLD.
  initial begin
    push1(1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    push1(4, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    wait_cyc(3);
    rst1 = 1'b0;                 // E = 3
    wait_cyc(10);
    push1(11, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    push1(12, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    push1(13, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1);
    push1(14, 1'b1, 1'b1, 1'b0, 1'b1, 16'h1);
    rst1 = 1'b1;
    req1 = 1'b1;
    wait_cyc(11);
    rst1 = 1'b0;                 // E = 11, request held through HOLD
    wait_cyc(20);
    push1(21, 1'b1, 1'b1, 1'b0, 1'b0, 16'h1);
    req1 = 1'b0;
  end

  // DUT0 stimulus and end of test.
  initial begin
    // POR: rst high for edges 1..5, E = 5
    push0(1, 4'b0000, 1'b0, 1'b1, 1'b0, 16'h0);
    push_rel0(5, 1'b0, 16'h0);
    wait_cyc(5);
    rst0 = 1'b0;

    // Full handshake: T = 41
    wait_cyc(40);
    push0(41, 4'b0000, 1'b0, 1'b1, 1'b0, 16'h1);
    push_rel0(41, 1'b1, 16'h1);
    req0 = 1'b1;
    wait_cyc(75);
    push0(76, 4'b1111, 1'b1, 1'b0, 1'b0, 16'h1);
    req0 = 1'b0;

    // Request dropped mid-sequence: T = 81, drop sampled at 91
    wait_cyc(80);
    push0(81, 4'b0000, 1'b0, 1'b1, 1'b0, 16'h2);
    push_rel0(81, 1'b0, 16'h2);
    req0 = 1'b1;
    wait_cyc(90);
    req0 = 1'b0;

    // rst mid-sequence at T+22, request held high throughout
    wait_cyc(120);
    push0(121, 4'b0000, 1'b0, 1'b1, 1'b0, 16'h3);
    push0(137, 4'b0001, 1'b0, 1'b1, 1'b0, 16'h3);
    push0(141, 4'b0011, 1'b0, 1'b1, 1'b0, 16'h3);
    push0(143, 4'b0000, 1'b0, 1'b1, 1'b0, 16'h0);
    push_rel0(144, 1'b0, 16'h0);
    push0(173, 4'b0000, 1'b0, 1'b1, 1'b0, 16'h1);
    push_rel0(173, 1'b1, 16'h1);
    push0(206, 4'b1111, 1'b1, 1'b0, 1'b0, 16'h1);
    req0 = 1'b1;
    wait_cyc(142);
    rst0 = 1'b1;                 // edges 143, 144 in reset
    wait_cyc(144);
    rst0 = 1'b0;                 // E = 144
    wait_cyc(205);
    req0 = 1'b0;

`ifdef CMN_RST_CTRL_CNT_EN
    // Counter saturation and clear by rst
    wait_cyc(210);
    push0(210, 4'b1111, 1'b1, 1'b0, 1'b0, 16'hFFFE);
    force dut0.rst_cnt = 16'hFFFE;
    #5;
    release dut0.rst_cnt;
    wait_cyc(212);
    push0(213, 4'b0000, 1'b0, 1'b1, 1'b0, 16'hFFFF);
    push_rel0(213, 1'b1, 16'hFFFF);
    push0(246, 4'b1111, 1'b1, 1'b0, 1'b0, 16'hFFFF);
    req0 = 1'b1;
    wait_cyc(245);
    req0 = 1'b0;
    wait_cyc(250);
    push0(251, 4'b0000, 1'b0, 1'b1, 1'b0, 16'hFFFF);
    push_rel0(251, 1'b1, 16'hFFFF);
    push0(284, 4'b1111, 1'b1, 1'b0, 1'b0, 16'hFFFF);
    req0 = 1'b1;
    wait_cyc(283);
    req0 = 1'b0;
    wait_cyc(290);
    push0(291, 4'b0000, 1'b0, 1'b1, 1'b0, 16'h0);
    push_rel0(291, 1'b0, 16'h0);
    rst0 = 1'b1;
    wait_cyc(291);
    rst0 = 1'b0;
    wait_cyc(335);
`else
    wait_cyc(225);
`endif

    // Every expected event must have been seen
    n_chk++;
    if (q0.size() != 0) begin
      n_fail++;
      $display("FAIL dut0_missing actual=%0d pending events required=0 (next cyc=%0d)",
               q0.size(), q0[0].cyc);
    end
    n_chk++;
    if (q1.size() != 0) begin
      n_fail++;
      $display("FAIL dut1_missing actual=%0d pending events required=0 (next cyc=%0d)",
               q1.size(), q1[0].cyc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #50000;
    $display("FAIL watchdog actual=time limit reached required=test end");
    $fatal(1);
  end

endmodule
